// File: rtl/fir_interpolator_if.sv
// fir_interpolator_if: sample handshake between a source and the polyphase
// interpolating FIR.
//   in_valid  source -> filter   input sample valid
//   in_ready  filter -> source   filter can accept a sample
//   in        source -> filter   signed input sample
//   out_valid filter -> sink     single-cycle pulse marking a valid out
//   out       filter -> sink     signed output sample, held between pulses
// master = sample source / sink side, slave = the filter.
interface fir_interpolator_if #(
    parameter int InputLengthBits = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic signed [InputLengthBits-1:0] in;
    logic                              out_valid;
    logic signed [InputLengthBits-1:0] out;

    modport master (
        output in_valid,
        output in,
        input  in_ready,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  in,
        output in_ready,
        output out_valid,
        output out
    );
endinterface

// File: rtl/fir_interpolator.sv
// fir_interpolator: polyphase interpolating FIR. Accepts one signed sample per
// handshake and emits InterpolationFactor filtered samples, evaluating one
// polyphase branch at a time on a single multiply-accumulate unit.
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  fir_interpolator_if.slave: in_valid/in_ready/in sample input,
//        out_valid/out filtered output (no backpressure)
module fir_interpolator #(
    parameter int InputLengthBits       = 8,
    parameter int CoefficientLengthBits = 10,
    parameter int AccumulatorLengthBits = 20,
    parameter int NumTaps               = 6,
    parameter int InterpolationFactor   = 2,
    parameter int OutputTruncationBits  = 9,
    parameter logic signed [CoefficientLengthBits-1:0] Coefficients [NumTaps] =
        '{10'sd64, 10'sd128, 10'sd256, 10'sd511, -10'sd128, -10'sd64}
) (
    input logic               clk,
    input logic               rst,
    fir_interpolator_if.slave bus
);
    localparam int DW = InputLengthBits;
    localparam int CW = CoefficientLengthBits;
    localparam int AW = AccumulatorLengthBits;
    localparam int PW = DW + CW;
    localparam int L  = InterpolationFactor;
    localparam int P  = (L >= 1) ? NumTaps / L : 1;
    localparam int T  = AW - DW - OutputTruncationBits;
    localparam int JW = (P > 1) ? $clog2(P) : 1;
    localparam int KW = (L > 1) ? $clog2(L) : 1;

    if (L < 1) begin : g_err_factor
        $error("InterpolationFactor must be at least 1");
    end
    if (L >= 1 && (NumTaps % L) != 0) begin : g_err_taps
        $error("NumTaps must be a multiple of InterpolationFactor");
    end
    if (T < 0) begin : g_err_width
        $error("AccumulatorLengthBits - OutputTruncationBits must be >= InputLengthBits");
    end

    typedef enum logic {
        IDLE,
        MAC
    } state_t;

    state_t                state;
    logic [KW-1:0]         k;
    logic [JW-1:0]         j;
    logic signed [AW-1:0]  acc;
    logic signed [DW-1:0]  x [P];
    logic signed [DW-1:0]  out_r;
    logic                  out_valid_r;

    logic signed [CW-1:0]  coef;
    logic signed [DW-1:0]  tap;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  sum;

    // Keep the sum only if its top T+1 bits are a pure sign extension;
    // otherwise clamp to the most positive / most negative sample.
    function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] s);
        logic [T:0] top;
        top = s[AW-1 -: T+1];
        if (top == '0 || top == '1) begin
            saturate = s[AW-1-T -: DW];
        end else if (s[AW-1]) begin
            saturate = {1'b1, {(DW-1){1'b0}}};
        end else begin
            saturate = {1'b0, {(DW-1){1'b1}}};
        end
    endfunction

    // Branch k uses every L-th prototype tap starting at k: h[j*L+k] * x[j].
    always_comb begin
        coef = '0;
        tap  = '0;
        for (int i = 0; i < NumTaps; i++) begin
            if (i == int'(j) * L + int'(k)) begin
                coef = Coefficients[i];
            end
        end
        for (int i = 0; i < P; i++) begin
            if (i == int'(j)) begin
                tap = x[i];
            end
        end
        prod = PW'(coef) * PW'(tap);
        sum  = acc + AW'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            j           <= '0;
            acc         <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < P; i++) begin
                x[i] <= '0;
            end
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x[0] <= bus.in;
                        for (int i = P - 1; i > 0; i--) begin
                            x[i] <= x[i-1];
                        end
                        k     <= '0;
                        j     <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (j == JW'(P - 1)) begin
                        // Last product of this branch: publish it next cycle.
                        out_r       <= saturate(sum);
                        out_valid_r <= 1'b1;
                        if (k != KW'(L - 1)) begin
                            k   <= k + 1'b1;
                            j   <= '0;
                            acc <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        acc <= sum;
                        j   <= j + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
endmodule

// File: tb/tb_fir_interpolator.sv
// tb_fir_interpolator: drives fir_interpolator with directed and randomized
// sample streams and compares every output against a zero-stuff-and-convolve
// reference computed in the bench.
module tb_fir_interpolator;
    localparam int L  = 2;
    localparam int NT = 6;
    localparam int OT = 9;
    localparam int DW = 8;

    int h_ref [NT] = '{64, 128, 256, 511, -128, -64};
    int imp_exp [12] = '{8, 16, 32, 63, -16, -8, 0, 0, 0, 0, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_interpolator_if #(.InputLengthBits(DW)) bus();

    fir_interpolator dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int got_q[$];
    int stim_q[$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) got_q.push_back(int'(bus.out));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: upsample by L with zero stuffing, convolve with the prototype,
    // floor-divide by 2^OT and clamp to the sample range.
    function automatic int model_out(input int n);
        int s;
        int t;
        s = 0;
        for (int m = 0; m < NT; m++) begin
            t = n - m;
            if (t >= 0 && (t % L) == 0 && (t / L) < stim_q.size())
                s += h_ref[m] * stim_q[t / L];
        end
        s = s >>> OT;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -9999;
    endfunction

    // junk: 0 never, 1 always, 2 randomly drive in_valid with in=100 while busy.
    task automatic send(input int v, input int junk);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1) begin
            if (junk == 1 || (junk == 2 && $urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b1;
                bus.in       = 8'sd100;
            end else begin
                bus.in_valid = 1'b0;
            end
            waited++;
            if (waited > 50) begin
                bus.in_valid = 1'b0;
                check("send_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in       = v[DW-1:0];
        stim_q.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out", int'(bus.out), 0);
        check("rst_ready_after", int'(bus.in_ready), 1);
        stim_q.delete();
        got_q.delete();
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, got_q.size(), stim_q.size() * L);
        for (int n = 0; n < got_q.size() && n < stim_q.size() * L; n++)
            check(tag, got_q[n], model_out(n));
    endtask

    task automatic impulse_run(input string tag, input int junk);
        send(64, junk);
        for (int i = 0; i < 5; i++) send(0, junk);
        repeat (12) @(negedge clk);
        check_seq(tag);
        for (int i = 0; i < 12; i++) check({tag, "_const"}, got_at(i), imp_exp[i]);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in       = '0;

        do_reset();

        // Cycle timing: handshake in cycle 0, back-to-back handshake in cycle 7.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in       = 8'sd64;
        stim_q.push_back(64);
        check("tim_hs_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            check("tim_valid", int'(bus.out_valid), int'(t == 4 || t == 7 || t == 11 || t == 14));
            check("tim_ready", int'(bus.in_ready), int'(t == 7 || t == 14));
            if (t == 7) begin
                bus.in_valid = 1'b1;
                bus.in       = '0;
                stim_q.push_back(0);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        check_seq("timing");

        // Impulse response.
        do_reset();
        impulse_run("impulse", 0);

        // Positive DC saturation.
        do_reset();
        for (int i = 0; i < 4; i++) send(127, 0);
        repeat (10) @(negedge clk);
        check_seq("dc_pos");
        for (int i = 4; i < 8; i++) check("dc_pos_const", got_at(i), (i % 2 == 0) ? 47 : 127);

        // Negative DC saturation.
        do_reset();
        for (int i = 0; i < 4; i++) send(-128, 0);
        repeat (10) @(negedge clk);
        check_seq("dc_neg");
        for (int i = 4; i < 8; i++) check("dc_neg_const", got_at(i), (i % 2 == 0) ? -48 : -128);

        // Reset mid-operation, out is still -128 from the previous run.
        got_q.delete();
        send(64, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("midrst_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        check("midrst_valid", int'(bus.out_valid), 0);
        check("midrst_out", int'(bus.out), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_output", got_q.size(), 0);
        stim_q.delete();
        got_q.delete();
        impulse_run("midrst_impulse", 0);

        // Ignored input pulses during MAC.
        do_reset();
        impulse_run("ignored", 1);

        // Randomized streams with idle gaps and stray in_valid pulses.
        for (int seg = 0; seg < 6; seg++) begin
            int n;
            do_reset();
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(int'($urandom_range(0, 255)) - 128, 2);
            end
            repeat (12) @(negedge clk);
            check_seq("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/fir_interpolator.md
# fir_interpolator

Polyphase interpolating FIR filter: accepts one signed input sample per handshake and emits InterpolationFactor filtered output samples at the higher rate. It sits upstream of the transmit/DAC path and is the rate-raising counterpart of the single-rate FIR filter. A single time-multiplexed multiply-accumulate unit evaluates one polyphase branch at a time. The output truncation and saturation rules match the single-rate FIR exactly.

## Interface
- InputLengthBits, 8, input and output sample width (signed)
- CoefficientLengthBits, 10, coefficient width (signed)
- AccumulatorLengthBits, 20, accumulator width
- NumTaps, 6, total prototype filter taps; must be a multiple of InterpolationFactor
- InterpolationFactor, 2, L; output samples produced per input sample, ≥ 1
- OutputTruncationBits, 9, LSBs dropped from the accumulator to form the output
- Coefficients, {64, 128, 256, 511, -128, -64}, prototype taps h[0..NumTaps-1], signed CoefficientLengthBits each
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample; high only in IDLE and low while rst is high
- in  in  InputLengthBits  signed input sample
- out_valid  out  1  single-cycle pulse marking a valid out
- out  out  InputLengthBits  signed output sample; holds its value between pulses

## Operation
- P = NumTaps/L taps per phase. A delay line x[0..P-1] holds the most recent input at x[0].
- Output for phase k (0..L-1): y_k = sum over j=0..P-1 of h[j*L+k] * x[j].
- Elaboration errors:
  - NumTaps % L != 0
  - L < 1
  - AccumulatorLengthBits - OutputTruncationBits < InputLengthBits
- States:
  - **IDLE**: in_ready=1. On in_valid: shift the delay line (x[0] <= in), set k=0, j=0, clear acc, go to MAC.
  - **MAC**: one product per cycle, acc <= acc + h[j*L+k]*x[j], j++.
    - On the last product (j=P-1), the full sum is saturated into out and out_valid is set for the next cycle.
    - If k<L-1: k++, j=0, acc cleared, stay in MAC.
    - Otherwise: go to IDLE.
- Arithmetic:
  - Products are full precision and sign-extended to AccumulatorLengthBits.
  - The accumulator wraps modulo 2^AccumulatorLengthBits; sizing it correctly is the designer's job.
- Output formation:
  - T = AccumulatorLengthBits - InputLengthBits - OutputTruncationBits.
  - If the top T+1 bits of the sum are all equal, out = sum[AccumulatorLengthBits-1-T : OutputTruncationBits]. This truncates toward negative infinity.
  - Otherwise saturate: out = -(2^(InputLengthBits-1)) if the sign bit is 1, else 2^(InputLengthBits-1)-1.
- There is no output backpressure. The downstream block must accept every out_valid pulse.
- in_valid asserted while in_ready=0 is ignored and the sample is not captured. The source must hold it until the handshake completes.

## Timing
- Reset:
  - out=0, out_valid=0, delay line all zero, acc=0, state IDLE.
  - in_ready=1 from the first cycle with rst low.
- Handshake in cycle c0 (in_valid & in_ready):
  - MAC runs in cycles c1..cP.
  - First out_valid is in cycle cP+1.
  - Subsequent outputs follow every P cycles: out_valid in cycle c(k+1)P+1 for phase k.
- The last out_valid (phase L-1) coincides with in_ready=1. The next input can be accepted in that same cycle.
- Maximum throughput: one input per L*P+1 cycles. For the defaults (L=2, P=3) that is 7 cycles.
- out_valid is never high for two consecutive cycles when P>1. When P=1, phases emit back to back.
- rst asserted mid-operation takes effect at the next edge:
  - Pending phases are discarded.
  - out_valid=0 and out=0 from the following cycle.
  - The delay line is cleared.
- Coefficient index h[j*L+k] never exceeds NumTaps-1.

## Test plan
- **Impulse:** in=64, then five inputs of 0, each sent as soon as in_ready is high, defaults. Required out sequence: 8, 16, 32, 63, -16, -8, followed by 0s.
- **Cycle timing:** handshake in cycle 0 gives out_valid in cycles 4 and 7 only, in_ready low in cycles 1–6 and high in cycle 7. A back-to-back handshake in cycle 7 gives out_valid in cycles 11 and 14.
- **Saturation (positive DC):** in=127 held for 4 inputs. Once the delay line is full, outputs alternate 47 (phase 0) and 127 (phase 1, which saturates from an unsaturated value of 142).
- **Saturation (negative DC):** in=-128 held for 4 inputs. Steady outputs alternate -48 and -128 (phase 1 saturated).
- **Ignored input:** pulse in_valid with in=100 during MAC cycles. The value must not enter the delay line, and outputs must equal the no-pulse reference.
- **Reset mid-operation:** assert rst in cycle 2 after accepting in=64. There must be no out_valid for that sample, out=0, and a following impulse must reproduce the impulse-test sequence exactly, with no residual history.
